// File: rtl/mixer_pkg.sv
// Shared types and sizing helpers for the track mixer and the effects blocks
// that will follow it.
//   state_t   : mix frame sequencer states
//   acc_width : accumulator width that cannot wrap when summing n gain-scaled
//               tracks plus one unity-gain monitor term
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    MONITOR = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // Product is w+g+1 bits (signed sample times zero-extended gain). The extra
  // clog2(n+1) bits absorb n track products plus the monitor term.
  function automatic int acc_width(input int w, input int g, input int n);
    return w + g + 1 + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/track_mixer_sat_clamp.sv
// sat_clamp: combinational signed saturation from IN_W to OUT_W bits.
//   din  : signed input, IN_W bits (IN_W > OUT_W)
//   dout : din clamped to [-2**(OUT_W-1), 2**(OUT_W-1)-1]
//   clip : high when the clamp changed the value
module sat_clamp #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  // The value fits when every bit from the output sign bit upward matches.
  logic [IN_W-OUT_W:0] top;
  assign top = din[IN_W-1:OUT_W-1];

  always_comb begin
    clip = !((&top) || !(|top));
    dout = din[OUT_W-1:0];
    if (clip) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                         : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/track_mixer.sv
// track_mixer: time-multiplexed multi-track playback mixer.
// A sample_strobe snapshots all tracks, gains, masks and the monitor input;
// the frame then scales and accumulates one track per cycle through a single
// multiplier, adds the monitor at unity, scales back by the gain fraction,
// saturates and emits one sample with a 1-cycle mix_valid pulse.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   sample_strobe  : start a frame (ignored and flagged as overrun while busy)
//   track_data     : NUM_TRACKS signed samples, track i at [i*W +: W]
//   track_valid    : per-track data present
//   track_en       : per-track user mute mask
//   gain           : NUM_TRACKS unsigned gains, track i at [i*G +: G]
//   monitor_in/_en : live input sample and its enable
//   clip_clr       : clear sticky clip/overrun
//   mix_out        : saturated mix, held between frames
//   mix_valid      : 1-cycle pulse when mix_out updates
//   busy           : frame in progress
//   clip, overrun  : sticky status flags
module track_mixer
  import mixer_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_TRACKS = 4,
  parameter int GAIN_WIDTH = 4,
  parameter int GAIN_FRAC  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_strobe,
  input  logic [NUM_TRACKS*WORD_WIDTH-1:0]   track_data,
  input  logic [NUM_TRACKS-1:0]              track_valid,
  input  logic [NUM_TRACKS-1:0]              track_en,
  input  logic [NUM_TRACKS*GAIN_WIDTH-1:0]   gain,
  input  logic [WORD_WIDTH-1:0]              monitor_in,
  input  logic                               monitor_en,
  input  logic                               clip_clr,
  output logic [WORD_WIDTH-1:0]              mix_out,
  output logic                               mix_valid,
  output logic                               busy,
  output logic                               clip,
  output logic                               overrun
);

  localparam int W  = WORD_WIDTH;
  localparam int N  = NUM_TRACKS;
  localparam int G  = GAIN_WIDTH;
  localparam int PW = W + G + 1;
  localparam int AW = acc_width(W, G, N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t state, state_nx;

  // Frame snapshot
  logic [N-1:0][W-1:0] data_q;
  logic [N-1:0][G-1:0] gain_q;
  logic [N-1:0]        live_q;   // en & valid folded together: both mean silence
  logic signed [W-1:0] mon_q;
  logic                mon_en_q;

  logic [IW-1:0]        idx;
  logic signed [AW-1:0] acc;

  logic start, acc_step, mon_step, out_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_strobe) state_nx = ACCUM;
      ACCUM:   if (idx == IW'(N - 1)) state_nx = MONITOR;
      MONITOR: state_nx = OUTPUT;
      OUTPUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    start    = 1'b0;
    acc_step = 1'b0;
    mon_step = 1'b0;
    out_step = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:    start    = sample_strobe;
      ACCUM:   acc_step = 1'b1;
      MONITOR: mon_step = 1'b1;
      OUTPUT:  out_step = 1'b1;
      default: ;
    endcase
  end

  // Shared multiplier fed by the idx-selected track
  logic signed [W-1:0]  d_sel;
  logic        [G-1:0]  g_sel;
  logic signed [G:0]    g_ext;
  logic signed [PW-1:0] prod;

  assign d_sel = data_q[idx];
  assign g_sel = gain_q[idx];
  assign g_ext = {1'b0, g_sel};
  assign prod  = live_q[idx] ? (PW'(d_sel) * PW'(g_ext)) : '0;

  logic signed [AW-1:0] r;
  logic signed [W-1:0]  sat;
  logic                 sat_clip;

  assign r = acc >>> GAIN_FRAC;  // floor toward -inf

  sat_clamp #(.IN_W(AW), .OUT_W(W)) u_clamp (
    .din  (r),
    .dout (sat),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      gain_q    <= '0;
      live_q    <= '0;
      mon_q     <= '0;
      mon_en_q  <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start) begin
        data_q   <= track_data;
        gain_q   <= gain;
        live_q   <= track_en & track_valid;
        mon_q    <= monitor_in;
        mon_en_q <= monitor_en;
        idx      <= '0;
        acc      <= '0;
      end
      if (acc_step) begin
        acc <= acc + AW'(prod);
        idx <= idx + IW'(1);
      end
      if (mon_step && mon_en_q)
        acc <= acc + (AW'(mon_q) <<< GAIN_FRAC);
      mix_valid <= out_step;
      if (out_step) mix_out <= sat;
      // Sets take priority over the clear in the same cycle.
      if (out_step && sat_clip) clip <= 1'b1;
      else if (clip_clr)        clip <= 1'b0;
      if (sample_strobe && busy) overrun <= 1'b1;
      else if (clip_clr)         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_track_mixer.sv
module tb_track_mixer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int G = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_strobe;
  logic [N*W-1:0]   track_data;
  logic [N-1:0]     track_valid;
  logic [N-1:0]     track_en;
  logic [N*G-1:0]   gain;
  logic [W-1:0]     monitor_in;
  logic             monitor_en;
  logic             clip_clr;
  logic [W-1:0]     mix_out;
  logic             mix_valid;
  logic             busy;
  logic             clip;
  logic             overrun;

  int tests = 0;
  int fails = 0;

  track_mixer #(.WORD_WIDTH(W), .NUM_TRACKS(N), .GAIN_WIDTH(G), .GAIN_FRAC(3)) dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .track_data(track_data),
    .track_valid(track_valid), .track_en(track_en), .gain(gain),
    .monitor_in(monitor_in), .monitor_en(monitor_en), .clip_clr(clip_clr),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input integer obs, input integer exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_trk(input int i, input int v, input int g);
    logic [31:0] vv, gg;
    vv = v; gg = g;
    track_data[i*W +: W] = vv[W-1:0];
    gain[i*G +: G]       = gg[G-1:0];
  endtask

  task automatic clear_trk();
    track_data = '0; gain = '0; track_en = '0; track_valid = '1;
    monitor_in = '0; monitor_en = 1'b0;
  endtask

  // Pulse strobe, wait for mix_valid (bounded), check latency, value, clip, pulse width.
  task automatic frame(input string tag, input int exp_mix, input int exp_clip);
    int k;
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    k = 0;
    while (k < 12) begin
      @(negedge clk); k++;
      if (mix_valid === 1'b1) break;
    end
    chk({tag, "_latency"}, k, 6);
    chk({tag, "_mix"}, $signed(mix_out), exp_mix);
    chk({tag, "_clip"}, clip, exp_clip);
    @(negedge clk);
    chk({tag, "_pulse"}, mix_valid, 0);
  endtask

  initial begin
    int k;
    int seen;
    rst = 1'b1; sample_strobe = 1'b0; clip_clr = 1'b0;
    clear_trk();
    repeat (3) @(negedge clk);
    chk("rst_mix", mix_out, 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1 unity
    clear_trk(); set_trk(0, 50, 8); track_en = 4'b0001;
    frame("unity", 50, 0);
    chk("unity_overrun", overrun, 0);

    // 2 saturation both ways, then clear
    clear_trk(); for (int i = 0; i < N; i++) set_trk(i, 100, 8); track_en = 4'b1111;
    frame("sat_pos", 127, 1);
    clear_trk(); set_trk(0, -100, 8); set_trk(1, -100, 8); track_en = 4'b0011;
    frame("sat_neg", -128, 1);
    @(negedge clk) clip_clr = 1'b1;
    @(negedge clk) clip_clr = 1'b0;
    chk("clip_clr", clip, 0);

    // 3 fraction / floor rounding
    clear_trk(); set_trk(0, -3, 4); track_en = 4'b0001;
    frame("floor_neg", -2, 0);
    clear_trk(); set_trk(0, 7, 12); track_en = 4'b0001;
    frame("frac_pos", 10, 0);

    // 4 masking + monitor: 30*8 - 20*8 = 80 -> 10
    clear_trk();
    set_trk(0, 30, 8); set_trk(1, 90, 8); set_trk(2, 90, 8); set_trk(3, 0, 8);
    track_en = 4'b0101; track_valid = 4'b1011;
    monitor_in = 8'hEC; monitor_en = 1'b1;
    frame("mask_mon", 10, 0);

    // 5 overrun + snapshot
    clear_trk(); set_trk(0, 50, 8); track_en = 4'b0001;
    @(negedge clk) sample_strobe = 1'b1;          // sampled at e0
    @(negedge clk) sample_strobe = 1'b0;
    @(negedge clk) begin sample_strobe = 1'b1; set_trk(0, 20, 8); end  // at e2, busy
    @(negedge clk) sample_strobe = 1'b0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_busy", busy, 1);
    k = 0;
    while (k < 12) begin
      @(negedge clk); k++;
      if (mix_valid === 1'b1) break;
    end
    chk("ovr_latency", k, 4);
    chk("ovr_snapshot", $signed(mix_out), 50);
    sample_strobe = 1'b1;                          // strobe in the mix_valid cycle
    @(negedge clk) sample_strobe = 1'b0;
    chk("b2b_busy", busy, 1);
    k = 0;
    while (k < 12) begin
      @(negedge clk); k++;
      if (mix_valid === 1'b1) break;
    end
    chk("b2b_latency", k, 6);
    chk("b2b_mix", $signed(mix_out), 20);
    @(negedge clk) clip_clr = 1'b1;
    @(negedge clk) clip_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // 6 reset mid-frame with flags and mix_out nonzero
    clear_trk(); for (int i = 0; i < N; i++) set_trk(i, 100, 8); track_en = 4'b1111;
    frame("pre_rst", 127, 1);
    @(negedge clk) sample_strobe = 1'b1;          // e0
    @(negedge clk) sample_strobe = 1'b0;          // after e0
    @(negedge clk) sample_strobe = 1'b1;          // e2: overrun while busy
    @(negedge clk) begin sample_strobe = 1'b0; rst = 1'b1; end  // e3 sees reset
    @(negedge clk) rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_mix", mix_out, 0);
    chk("mrst_clip", clip, 0);
    chk("mrst_overrun", overrun, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (mix_valid !== 1'b0) seen++;
    end
    chk("mrst_no_valid", seen, 0);
    clear_trk(); set_trk(2, -40, 8); set_trk(3, 16, 4); track_en = 4'b1100;
    frame("post_rst", -32, 0);                    // (-320 + 64) / 8

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
